// File: rtl/multi_byte_add_sequencer_pkg.sv
// Shared types and defaults for the byte-serial multi-precision add/sub sequencer.
package multi_byte_add_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NBYTES_DEFAULT = 4;

   // A single-byte operand still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eight_bit_full_adder.sv
// 8-bit ripple adder cell from the shared adder library.
module eight_bit_full_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   assign {cout, sum} = 9'(a) + 9'(b) + 9'(cin);

endmodule

// File: rtl/multi_byte_add_sequencer_datapath.sv
// Byte datapath: selects the current operand byte, conditionally inverts B,
// and carries between bytes through a register around one 8-bit adder.
module multi_byte_add_sequencer_datapath
   import multi_byte_add_sequencer_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEFAULT,
   parameter int IW     = idx_width(NBYTES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                step,
   input  logic                sub_in,
   input  logic [8*NBYTES-1:0] a_reg,
   input  logic [8*NBYTES-1:0] b_reg,
   input  logic                sub_reg,
   input  logic [IW-1:0]       idx,
   output logic [7:0]          sum_byte,
   output logic                carry_out,
   output logic                a_msb,
   output logic                bx_msb
);

   logic [7:0] a_byte;
   logic [7:0] b_byte;
   logic [7:0] bx_byte;
   logic       carry_reg;

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx == IW'(k)) begin
            a_byte = a_reg[8*k +: 8];
            b_byte = b_reg[8*k +: 8];
         end
      end
   end

   // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
   assign bx_byte = b_byte ^ {8{sub_reg}};
   assign a_msb   = a_byte[7];
   assign bx_msb  = bx_byte[7];

   eight_bit_full_adder u_adder (
      .a    (a_byte),
      .b    (bx_byte),
      .cin  (carry_reg),
      .sum  (sum_byte),
      .cout (carry_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_reg <= 1'b0;
      end else if (load) begin
         carry_reg <= sub_in;
      end else if (step) begin
         carry_reg <= carry_out;
      end
   end

endmodule

// File: rtl/multi_byte_add_sequencer.sv
// Multi-precision add/sub sequencer: one byte per clock, LSB first, with a
// start/busy/done handshake and results held until the next accepted start.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | waiting for start; outputs hold the last result
//   RUN     | one operand byte per cycle through the shared adder
//   DONE    | one-cycle done pulse; start is ignored here
module multi_byte_add_sequencer
   import multi_byte_add_sequencer_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                sub,
   input  logic [8*NBYTES-1:0] a,
   input  logic [8*NBYTES-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] result,
   output logic                cout,
   output logic                overflow
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = idx_width(NBYTES);

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic            sub_reg;
   logic [IW-1:0]   idx;
   logic            accept;
   logic            step;
   logic            last;
   logic [7:0]      sum_byte;
   logic            carry_out;
   logic            a_msb;
   logic            bx_msb;

   assign last = (idx == IW'(NBYTES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sub_reg  <= 1'b0;
         idx      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_reg   <= a;
         b_reg   <= b;
         sub_reg <= sub;
         idx     <= '0;
      end else if (step) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (idx == IW'(k)) begin
               result[8*k +: 8] <= sum_byte;
            end
         end
         if (last) begin
            idx      <= '0;
            cout     <= carry_out;
            // Signed overflow: like-signed operands giving an opposite-signed result.
            overflow <= (a_msb == bx_msb) && (sum_byte[7] != a_msb);
         end else begin
            idx <= idx + IW'(1);
         end
      end
   end

   multi_byte_add_sequencer_datapath #(
      .NBYTES (NBYTES),
      .IW     (IW)
   ) u_datapath (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .step      (step),
      .sub_in    (sub),
      .a_reg     (a_reg),
      .b_reg     (b_reg),
      .sub_reg   (sub_reg),
      .idx       (idx),
      .sum_byte  (sum_byte),
      .carry_out (carry_out),
      .a_msb     (a_msb),
      .bx_msb    (bx_msb)
   );

endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Bench for multi_byte_add_sequencer (NBYTES=4): arithmetic model plus directed vectors.
module tb_multi_byte_add_sequencer;

   localparam int NBYTES = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        cout;
   logic        overflow;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit chk_en   = 0;

   // Model: phase 0 = idle, 1..NBYTES = running, NBYTES+1 = done cycle.
   int          m_phase  = 0;
   logic [31:0] m_result = '0;
   logic        m_cout   = 1'b0;
   logic        m_ovf    = 1'b0;
   logic [31:0] p_result;
   logic        p_cout;
   logic        p_ovf;

   multi_byte_add_sequencer #(.NBYTES(NBYTES)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected outcome straight from integer arithmetic.
   task automatic compute(input logic [31:0] ia, input logic [31:0] ib, input logic is);
      longint sa;
      longint sb;
      longint r;
      logic [32:0] wide;
      sa = longint'($signed(ia));
      sb = longint'($signed(ib));
      r  = is ? (sa - sb) : (sa + sb);
      p_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      if (is) begin
         p_result = ia - ib;
         p_cout   = (ia >= ib);
      end else begin
         wide     = {1'b0, ia} + {1'b0, ib};
         p_result = wide[31:0];
         p_cout   = wide[32];
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_phase  = 0;
         m_result = '0;
         m_cout   = 1'b0;
         m_ovf    = 1'b0;
      end else if (m_phase == 0) begin
         if (start) begin
            compute(a, b, sub);
            m_phase = 1;
         end
      end else if (m_phase <= NBYTES) begin
         m_phase = m_phase + 1;
         if (m_phase == NBYTES + 1) begin
            m_result = p_result;
            m_cout   = p_cout;
            m_ovf    = p_ovf;
         end
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, (m_phase >= 1 && m_phase <= NBYTES));
         check("done", done, (m_phase == NBYTES + 1));
         if (m_phase == 0 || m_phase == NBYTES + 1) begin
            check("result", result, m_result);
            check("cout", cout, m_cout);
            check("overflow", overflow, m_ovf);
         end
      end
   end

   // Drives one operation and checks latency and literal results at done.
   task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        input logic [31:0] er, input logic ec, input logic eo, input string nm);
      int n;
      @(posedge clk); #1;
      a = ia; b = ib; sub = is; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, " latency"}, n, NBYTES + 1);
      check({nm, " result"}, result, er);
      check({nm, " cout"}, cout, ec);
      check({nm, " overflow"}, overflow, eo);
   endtask

   initial begin
      int n;
      int seen;
      int done_cyc[3];
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset result", result, 32'h0);
      check("reset cout/ovf", {cout, overflow}, 2'b00);

      do_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "add carry");
      do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "full chain");
      do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "signed ovf");
      do_op(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub borrow");
      do_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "sub ovf");
      do_op(32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 1'b0, 1'b0, "add mixed");
      do_op(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, "sub zero");

      // Start pulse during RUN must be ignored.
      @(posedge clk); #1;
      a = 32'h00000001; b = 32'h00000002; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 32'h11111111; b = 32'h22222222; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 3;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("ignored start latency", n, NBYTES + 1);
      check("ignored start result", result, 32'h00000003);
      repeat (3) begin
         @(posedge clk); #1;
         check("ignored start no extra op", {busy, done}, 2'b00);
      end

      // Start held high: done every NBYTES+2 cycles.
      @(posedge clk); #1;
      a = 32'h00000010; b = 32'h00000020; sub = 1'b0; start = 1'b1;
      n = 0;
      seen = 0;
      while (seen < 3 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) begin
            done_cyc[seen] = n;
            seen++;
         end
      end
      start = 1'b0;
      check("held start pulses", seen, 3);
      check("held start done0", done_cyc[0], 5);
      check("held start done1", done_cyc[1], 11);
      check("held start done2", done_cyc[2], 17);
      check("held start result", result, 32'h00000030);

      // Reset in cycle 2 of an operation aborts it.
      @(posedge clk); #1;
      a = 32'h0000000A; b = 32'h00000003; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort result", result, 32'h0);
      check("abort cout/ovf", {cout, overflow}, 2'b00);
      repeat (6) begin
         @(posedge clk); #1;
         check("abort no done", done, 1'b0);
      end
      do_op(32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 1'b1, 1'b0, "after reset");

      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_byte_add_sequencer.md
Name: multi_byte_add_sequencer

Overview:
Sequenced multi-precision adder/subtractor built on one shared 8-bit ripple adder. It processes one byte per clock, least-significant byte first, and keeps the carry in a register between bytes. This gives a wide add/sub without instantiating a wide adder, and it is the controller the ALU datapath uses for operands wider than 8 bits. Control uses a start/busy/done handshake, and results are held until the next accepted operation.

Parameters:
NBYTES, 4, number of bytes per operand (must be >= 1). Operand width W = 8*NBYTES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; latched with operands
a  input  W  operand A; latched on accepted start
b  input  W  operand B; latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result, cout and overflow are valid from this cycle
result  output  W  sum or difference; held until the next accepted start
cout  output  1  final carry; for subtract, 1 = no borrow
overflow  output  1  signed two's-complement overflow of the full W-bit operation

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; busy=0, done=0, result=0, cout=0, overflow=0.
  - byte index and carry register are cleared.
  - reset overrides everything: it aborts an operation in progress, no done is produced, and a start in the same cycle is ignored.
- IDLE:
  - start=1 accepts the request: latch a, b, sub; carry register <= sub; byte index <= 0; go to RUN.
  - start=0: stay in IDLE.
- RUN, per cycle with i = byte index:
  - adder inputs: a_reg[8i+7:8i], b_reg[8i+7:8i] XOR {8{sub_reg}}, carry-in = carry register.
  - result[8i+7:8i] <= sum; carry register <= adder carry-out; i <= i+1.
  - when i = NBYTES-1: cout <= carry-out, overflow is computed, go to DONE.
- Overflow rule: (a_msb == b'_msb) AND (result_msb != a_msb), where b' is the inverted B when sub=1.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE unconditionally. A start seen in DONE is ignored.
- Latency and throughput:
  - start accepted in cycle 0 → busy high in cycles 1..NBYTES → done high in cycle NBYTES+1.
  - with start held high, a new operation is accepted every NBYTES+2 cycles.
- start or operand changes while busy or in DONE are ignored; the latched operands are unaffected.
- result, cout and overflow update only in RUN. Upper result bytes keep their previous values until they are overwritten.
  - The previous result is therefore not stable during RUN. Consumers sample on done only.
- NBYTES=1: a single RUN cycle, done in cycle 2.
- Byte index width is max(1, $clog2(NBYTES)). The index never exceeds NBYTES-1.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NBYTES default.
- One sub-module: a single eight_bit_full_adder instance from lib/adder as the byte datapath.
  - Byte select, B inversion and the carry register live in this block.
  - No other adder logic is allowed.

Test Plan (NBYTES=4):
- Add with carry propagation: a=0x000000FF, b=0x00000001, sub=0, start in cycle 0 → busy in cycles 1-4; in cycle 5 done=1, result=0x00000100, cout=0, overflow=0.
- Full carry chain: a=0xFFFFFFFF, b=0x00000001, add → result=0x00000000, cout=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, add → result=0x80000000, cout=0, overflow=1.
- Subtract with borrow: a=0x00000005, b=0x00000007, sub=1 → result=0xFFFFFFFE, cout=0, overflow=0. Also a=0x80000000, b=0x00000001, sub=1 → result=0x7FFFFFFF, cout=1, overflow=1.
- Ignored start: during RUN, pulse start with a=0x11111111, b=0x22222222 → done still reports the first operation's result, and no extra operation occurs. Separately, with start held high continuously, done pulses in cycles 5, 11 and 17.
- Reset mid-operation: assert rst in cycle 2 of an operation → from cycle 3 busy=0, result=0, cout=0, overflow=0, and no done. A new start after reset completes normally.
